// File: rtl/control_unit.sv
// rtl/control_unit.sv - fetch/decode/execute sequencer for the 16-bit accumulator machine
module control_unit #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic [3:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_result,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] ac,
  output logic [11:0] pc,
  output logic        halted
);

  typedef enum logic [2:0] {FETCH, LOADIR, EXEC, INDIR, MEMRD, IOWAIT, HALT} state_t;

  state_t      state, state_d;
  logic [11:0] pc_q, pc_d, mar_q, mar_d;
  logic [15:0] ac_q, ac_d, out_data_q, out_data_d;
  logic [5:0]  ir_q, ir_d;  // opcode and skip condition; the operand field lives in MAR
  logic        out_valid_q, out_valid_d, ind_done_q, ind_done_d;
  logic [3:0]  opcode;
  logic        skip;

  assign opcode    = ir_q[5:2];
  assign alu_a     = ac_q;
  assign alu_b     = mem_rdata;
  assign alu_op    = (state == MEMRD && opcode == 4'h4) ? 4'b0001 : 4'b0000;
  assign ac        = ac_q;
  assign pc        = pc_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign halted    = (state == HALT);

  always_comb begin
    case (ir_q[1:0])
      2'b00:   skip = ac_q[15];
      2'b01:   skip = (ac_q == 16'h0000);
      2'b10:   skip = !ac_q[15] && (ac_q != 16'h0000);
      default: skip = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state;
    pc_d        = pc_q;
    mar_d       = mar_q;
    ir_d        = ir_q;
    ac_d        = ac_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ind_done_d  = ind_done_q;
    mem_addr    = {4'h0, pc_q};
    mem_we      = 1'b0;
    mem_wdata   = ac_q;
    in_ready    = 1'b0;
    case (state)
      FETCH: state_d = LOADIR;
      LOADIR: begin
        ir_d       = mem_rdata[15:10];
        mar_d      = mem_rdata[11:0];
        pc_d       = pc_q + 12'd1;
        ind_done_d = 1'b0;
        state_d    = EXEC;
      end
      EXEC: begin
        state_d = FETCH;
        case (opcode)
          4'h0: begin
            mem_addr  = {4'h0, mar_q};
            mem_we    = 1'b1;
            mem_wdata = {4'h0, pc_q};
            pc_d      = mar_q + 12'd1;
          end
          4'h1, 4'h3, 4'h4: begin
            mem_addr = {4'h0, mar_q};
            state_d  = MEMRD;
          end
          4'h2: begin
            mem_addr = {4'h0, mar_q};
            mem_we   = 1'b1;
          end
          4'h5: state_d = IOWAIT;
          4'h6: begin
            out_data_d  = ac_q;
            out_valid_d = 1'b1;
            state_d     = IOWAIT;
          end
          4'h7: state_d = HALT;
          4'h8: if (skip) pc_d = pc_q + 12'd1;
          4'h9: pc_d = mar_q;
          4'hA: ac_d = 16'h0000;
          4'hB, 4'hC, 4'hD, 4'hE: begin
            mem_addr = {4'h0, mar_q};
            if (!ind_done_q)
              state_d = INDIR;
            else if (opcode == 4'hE)
              mem_we = 1'b1;
            else if (opcode != 4'hC)
              state_d = MEMRD;
          end
          default: ;
        endcase
      end
      INDIR: begin
        if (opcode == 4'hC) begin
          pc_d    = mem_rdata[11:0];
          state_d = FETCH;
        end else begin
          mar_d      = mem_rdata[11:0];
          ind_done_d = 1'b1;
          state_d    = EXEC;
        end
      end
      MEMRD: begin
        if (opcode == 4'h1 || opcode == 4'hD)
          ac_d = mem_rdata;
        else
          ac_d = alu_result;
        state_d = FETCH;
      end
      IOWAIT: begin
        if (opcode == 4'h5) begin
          in_ready = 1'b1;
          if (in_valid) begin
            ac_d    = in_data;
            state_d = FETCH;
          end
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = FETCH;
        end
      end
      HALT: state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FETCH;
      pc_q        <= RESET_PC;
      mar_q       <= 12'h000;
      ir_q        <= 6'h00;
      ac_q        <= 16'h0000;
      out_data_q  <= 16'h0000;
      out_valid_q <= 1'b0;
      ind_done_q  <= 1'b0;
    end else begin
      state       <= state_d;
      pc_q        <= pc_d;
      mar_q       <= mar_d;
      ir_q        <= ir_d;
      ac_q        <= ac_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ind_done_q  <= ind_done_d;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed scoreboard bench for control_unit with memory and ALU models
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [3:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [15:0] in_data, out_data, ac;
  logic        in_valid, in_ready, out_valid, out_ready, halted;
  logic [11:0] pc;

  logic [15:0] mem [0:4095];
  logic        ld_en;
  logic [11:0] ld_addr;
  logic [15:0] ld_data;

  string       tq[$];
  logic [15:0] vq[$];
  int          n_assert = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .reset_n(reset_n), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .ac(ac), .pc(pc), .halted(halted)
  );

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[11:0]];
  end

  assign alu_result = (alu_op == 4'b0001) ? alu_a - alu_b : alu_a + alu_b;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [11:0] a, input logic [15:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  task automatic push(input string t, input logic [15:0] v);
    tq.push_back(t);
    vq.push_back(v);
  endtask

  task automatic pop_check(input logic [15:0] obs);
    string       t;
    logic [15:0] e;
    n_assert++;
    if (tq.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_underflow observed=%h", obs);
    end else begin
      t = tq.pop_front();
      e = vq.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;

    // Program: Load 4, Add 5, Store 6, Halt
    push("rst_mem_addr", 16'h0000); push("rst_mem_we", 16'h0000); push("rst_ac", 16'h0000);
    push("rst_pc", 16'h0000); push("rst_halted", 16'h0000); push("rst_out_valid", 16'h0000);
    push("rst_in_ready", 16'h0000);
    push("prog_exec_addr", 16'h0004); push("prog_pc_after_ir", 16'h0001);
    push("prog_halted_13", 16'h0000); push("prog_halted_14", 16'h0001); push("prog_pc", 16'h0004);
    push("prog_ac", 16'h0010); push("prog_mem6", 16'h0010); push("prog_halt_we", 16'h0000);
    load(12'h000, 16'h1004); load(12'h001, 16'h3005); load(12'h002, 16'h2006);
    load(12'h003, 16'h7000); load(12'h004, 16'h0007); load(12'h005, 16'h0009);
    pop_check(mem_addr); pop_check({15'h0, mem_we}); pop_check(ac); pop_check({4'h0, pc});
    pop_check({15'h0, halted}); pop_check({15'h0, out_valid}); pop_check({15'h0, in_ready});
    reset_n = 1'b1;
    tick(2);  pop_check(mem_addr); pop_check({4'h0, pc});
    tick(11); pop_check({15'h0, halted});
    tick(1);  pop_check({15'h0, halted}); pop_check({4'h0, pc}); pop_check(ac);
    pop_check(mem[6]); pop_check({15'h0, mem_we});

    // Wrap: 0xFFFF + 2
    reset_n = 1'b0;
    push("wrap_load", 16'hFFFF); push("wrap_add", 16'h0001); push("wrap_add_halt", 16'h0001);
    load(12'h000, 16'h1100); load(12'h001, 16'h3101); load(12'h002, 16'h7000);
    load(12'h100, 16'hFFFF); load(12'h101, 16'h0002);
    reset_n = 1'b1;
    tick(4);  pop_check(ac);
    tick(7);  pop_check(ac); pop_check({15'h0, halted});

    // Wrap: Clear then Subt 1
    reset_n = 1'b0;
    push("subt_wrap", 16'hFFFF); push("subt_halt", 16'h0001);
    load(12'h000, 16'hA000); load(12'h001, 16'h4102); load(12'h002, 16'h7000);
    load(12'h102, 16'h0001);
    reset_n = 1'b1;
    tick(10); pop_check(ac); pop_check({15'h0, halted});

    // PC wrap: Jump 0xFFF, fetch there
    reset_n = 1'b0;
    push("jump_pc", 16'h0FFF); push("jump_fetch_addr", 16'h0FFF);
    push("pc_wrap", 16'h0000); push("pc_wrap_halt", 16'h0001);
    load(12'h000, 16'h9FFF); load(12'hFFF, 16'h7000);
    reset_n = 1'b1;
    tick(3); pop_check({4'h0, pc}); pop_check(mem_addr);
    tick(3); pop_check({4'h0, pc}); pop_check({15'h0, halted});

    // Skipcond 0x8400 with AC=0
    reset_n = 1'b0;
    push("skip_eq_pc", 16'h0002); push("skip_eq_halt_pc", 16'h0003);
    load(12'h000, 16'h8400); load(12'h001, 16'h7000); load(12'h002, 16'h7000);
    reset_n = 1'b1;
    tick(3); pop_check({4'h0, pc});
    tick(3); pop_check({4'h0, pc});

    // Skipcond 0x8000 / 0x8800 with AC=0x8000
    reset_n = 1'b0;
    push("skip_neg_ac", 16'h8000); push("skip_neg_pc", 16'h0003);
    load(12'h010, 16'h8000); load(12'h000, 16'h1010); load(12'h001, 16'h8000);
    load(12'h002, 16'h7000); load(12'h003, 16'h7000);
    reset_n = 1'b1;
    tick(7); pop_check(ac); pop_check({4'h0, pc});
    reset_n = 1'b0;
    push("noskip_pos_pc", 16'h0002);
    load(12'h001, 16'h8800);
    reset_n = 1'b1;
    tick(7); pop_check({4'h0, pc});

    // LoadI through mem[0x10]
    reset_n = 1'b0;
    push("loadi_5", 16'h0000); push("loadi_6", 16'h1234); push("loadi_pc", 16'h0001);
    load(12'h010, 16'h0020); load(12'h020, 16'h1234); load(12'h000, 16'hD010); load(12'h001, 16'h7000);
    reset_n = 1'b1;
    tick(5); pop_check(ac);
    tick(1); pop_check(ac); pop_check({4'h0, pc});

    // JumpI through mem[0x11]
    reset_n = 1'b0;
    push("jumpi_pc", 16'h0040); push("jumpi_halt", 16'h0001);
    load(12'h011, 16'h0040); load(12'h040, 16'h7000); load(12'h000, 16'hC011);
    reset_n = 1'b1;
    tick(4); pop_check({4'h0, pc});
    tick(3); pop_check({15'h0, halted});

    // JnS 0x030 located at address 5
    reset_n = 1'b0;
    push("jns_pc", 16'h0031); push("jns_ret", 16'h0006); push("jns_halt", 16'h0001);
    load(12'h000, 16'h9005); load(12'h005, 16'h0030); load(12'h031, 16'h7000);
    reset_n = 1'b1;
    tick(6); pop_check({4'h0, pc}); pop_check(mem[12'h030]);
    tick(3); pop_check({15'h0, halted});

    // Output stalled by out_ready low for 5 cycles
    reset_n = 1'b0;
    push("out_valid", 16'h0001); push("out_data", 16'hABCD);
    for (int i = 0; i < 5; i++) begin
      push("out_hold_valid", 16'h0001); push("out_hold_data", 16'hABCD);
    end
    push("out_done_valid", 16'h0000); push("out_done_addr", 16'h0002);
    load(12'h010, 16'hABCD); load(12'h000, 16'h1010); load(12'h001, 16'h6000); load(12'h002, 16'h7000);
    reset_n = 1'b1;
    tick(7); pop_check({15'h0, out_valid}); pop_check(out_data);
    for (int i = 0; i < 5; i++) begin
      tick(1); pop_check({15'h0, out_valid}); pop_check(out_data);
    end
    out_ready = 1'b1;
    tick(1); pop_check({15'h0, out_valid}); pop_check(mem_addr);
    out_ready = 1'b0;

    // Input with data already valid
    reset_n = 1'b0;
    push("in_ready", 16'h0001); push("in_ac_before", 16'h0000); push("in_ac", 16'hBEEF);
    push("in_ready_drop", 16'h0000);
    load(12'h000, 16'h5000); load(12'h001, 16'h7000);
    in_data = 16'hBEEF; in_valid = 1'b1;
    reset_n = 1'b1;
    tick(3); pop_check({15'h0, in_ready}); pop_check(ac);
    tick(1); pop_check(ac); pop_check({15'h0, in_ready});
    in_valid = 1'b0;

    // Reset asserted during Store EXEC
    reset_n = 1'b0;
    push("store_we", 16'h0001); push("store_addr", 16'h0050); push("store_wdata", 16'h1111);
    push("abort_we", 16'h0000); push("abort_pc", 16'h0000); push("abort_ac", 16'h0000);
    push("abort_mem", 16'h5555);
    load(12'h010, 16'h1111); load(12'h050, 16'h5555); load(12'h000, 16'h1010);
    load(12'h001, 16'h2050); load(12'h002, 16'h7000);
    reset_n = 1'b1;
    tick(6); pop_check({15'h0, mem_we}); pop_check(mem_addr); pop_check(mem_wdata);
    reset_n = 1'b0;
    #1;
    pop_check({15'h0, mem_we}); pop_check({4'h0, pc}); pop_check(ac);
    tick(1); pop_check(mem[12'h050]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Fetch/decode/execute sequencer for the 16-bit accumulator machine. It owns PC, IR, MAR and AC. It drives `MainMemory` (synchronous read, one-cycle latency) and the combinational `ALU`. Instruction word: [15:12] opcode, [11:0] operand address, zero-extended to 16 bits on `mem_addr`.

## Interface
- RESET_PC, 12'h000, PC value loaded on reset

- clk  in  1  rising-edge clock, shared with MainMemory
- reset_n  in  1  asynchronous, active-low; clears all state
- mem_addr  out  16  memory address (combinational from state/PC/MAR)
- mem_wdata  out  16  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  16  MainMemory data_out, valid the cycle after the address is presented
- alu_op  out  4  ALU opcode (0000 add, 0001 subtract)
- alu_a, alu_b  out  16 each  ALU operands: AC and mem_rdata
- alu_result  in  16  ALU result
- in_data  in  16  input port data
- in_valid  in  1  input data valid
- in_ready  out  1  input data accepted
- out_data  out  16  output port data (registered)
- out_valid  out  1  output data valid
- out_ready  in  1  consumer ready
- ac, pc  out  16 / 12  architectural AC and PC, for debug
- halted  out  1  high in HALT state

## Operation
- States: FETCH, LOADIR, EXEC, INDIR, MEMRD, IOWAIT, HALT.
- FETCH: mem_addr=PC, mem_we=0. Next state LOADIR.
- LOADIR: IR<=mem_rdata; MAR<=mem_rdata[11:0]; PC<=PC+1, wrapping 12'hFFF->12'h000; clear ind_done. Next state EXEC.
- EXEC, decoded on IR[15:12]:
  - 0 JnS: write PC to mem[MAR]; PC<=MAR+1.
  - 1 Load, 3 Add, 4 Subt: mem_addr=MAR, then MEMRD.
  - 2 Store: mem_we=1, mem_wdata=AC, for exactly one cycle.
  - 5 Input, 6 Output: go to IOWAIT. Output also sets out_data<=AC and out_valid<=1.
  - 7 Halt: go to HALT.
  - 8 Skipcond: test IR[11:10]. 00 skips if AC<0 (signed), 01 if AC==0, 10 if AC>0, 11 never. A skip sets PC<=PC+1.
  - 9 Jump: PC<=MAR.
  - A Clear: AC<=0.
  - B AddI, C JumpI, D LoadI, E StoreI: if !ind_done, mem_addr=MAR and go to INDIR. Otherwise behave as Add/Load/Store respectively.
  - F: NOP.
  - Any op not listed as going elsewhere returns to FETCH.
- INDIR:
  - JumpI: PC<=mem_rdata[11:0], then FETCH.
  - Other indirect ops: MAR<=mem_rdata[11:0], ind_done<=1, then EXEC.
- MEMRD: Load sets AC<=mem_rdata. Add/Subt set AC<=alu_result, with alu_op=0000/0001. Next state FETCH.
- Arithmetic: AC wraps mod 2^16, with no flags. alu_a=AC and alu_b=mem_rdata at all times; alu_op=0000 except during a Subt MEMRD.
- IOWAIT:
  - Input: in_ready=1. On in_valid&&in_ready, AC<=in_data, then FETCH.
  - Output: hold out_valid and out_data until out_ready is sampled high, then clear out_valid and go to FETCH.
- HALT: absorbing state; mem_we=0, halted=1. Only reset leaves it.

## Timing
- Reset values: PC=RESET_PC, AC=IR=MAR=0, state=FETCH, mem_we=0, out_valid=0, out_data=0, in_ready=0, halted=0, ind_done=0.
- Reset behaviour: takes effect immediately. A Store in flight is aborted and mem_we drops in the same cycle because it is combinational from state.
- Cycles per instruction, FETCH to next FETCH:
  - Clear, Jump, Skipcond, Store, JnS, NOP: 3
  - Load, Add, Subt: 4
  - JumpI: 4
  - StoreI: 5
  - LoadI, AddI: 6
  - Input/Output: 3 + wait cycles, minimum 4 (handshake sampled in IOWAIT).
  - Halt: 3 cycles to reach HALT.
- mem_we is never high outside EXEC.
- No memory read is issued in a cycle where mem_we=1.
- PC+1 from 12'hFFF wraps to 12'h000. This applies to LOADIR, skip and JnS alike.
- out_valid must not drop without a handshake. out_data is stable while out_valid=1.

## Test plan
- Reset: hold reset_n low, then release → mem_addr=0x0000, mem_we=0, ac=0, pc=0, halted=0; first IR loads from mem[0].
- Program: mem[0..5]=1004,3005,2006,7000,0007,0009 → mem[6]=0x0010, halted=1 after 14 cycles, pc=0x004.
- Wrap: Load 0xFFFF then Add 0x0002 → AC=0x0001. Clear then Subt 0x0001 → AC=0xFFFF. Jump 0xFFF, then fetch there → pc=0x000.
- Skipcond:
  - AC=0 with 0x8400 → skip, pc +2 over the next instruction.
  - AC=0x8000 with 0x8000 → skip.
  - AC=0x8000 with 0x8800 → no skip.
- Indirect/JnS:
  - mem[0x10]=0x0020, mem[0x20]=0x1234; LoadI 0xD010 → AC=0x1234 in 6 cycles.
  - JnS 0x0030 at address 5 → mem[0x30]=0x0006, pc=0x031.
- I/O and reset:
  - Output with out_ready low for 5 cycles → out_valid and out_data held; completes on the cycle out_ready is sampled high.
  - Input with in_valid=1, in_data=0xBEEF → AC=0xBEEF.
  - reset_n low during Store EXEC → mem_we=0 immediately, pc=0.
